// File: rtl/bcd_pkg.sv
// Shared BCD conversion definitions: FSM encoding, digit constants and a
// power-of-ten helper for elaboration-time width checks.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/busy/valid handshake bundle between digit-entry logic and the
// BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int N_DIGITS = 6,
  parameter int BIN_W    = 20
);
  logic                                 start;
  logic [bcd_pkg::DIGIT_W*N_DIGITS-1:0] bcd_in;
  logic                                 busy;
  logic                                 valid;
  logic [BIN_W-1:0]                     bin_out;
  logic                                 err;

  modport master (output start, bcd_in, input busy, valid, bin_out, err);
  modport slave  (input start, bcd_in, output busy, valid, bin_out, err);
endinterface

// File: rtl/bcd2bin_seq_mul10_add.sv
// Combinational acc*10 + digit step, built from shifts so no multiplier is
// needed; result wraps at W bits, so callers size W for headroom.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [W-1:0]       sum
);

  assign sum = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, most-significant
// digit first; non-decimal digits force a zero result with err set.
//
// state  | meaning
// S_IDLE | waiting for start; operand captured when start is seen
// S_CONV | accumulating one digit per cycle, idx counting down to 0
// S_DONE | valid pulse; bin_out/err were loaded on the edge entering here
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int BIN_W    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_seq_if.slave  bus
);

  localparam int ACC_W = BIN_W + 4;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int OP_W  = DIGIT_W * N_DIGITS;

  if (pow10(N_DIGITS) - 64'd1 >= (64'd1 << BIN_W)) begin : g_width_check
    $fatal(1, "bcd2bin_seq: BIN_W too narrow for N_DIGITS");
  end

  state_t              state, state_nxt;
  logic [OP_W-1:0]     operand;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [IDX_W-1:0]    idx;
  logic                err_acc;
  logic [BIN_W-1:0]    bin_q;
  logic                err_q;
  logic [DIGIT_W-1:0]  digit;
  logic                err_final;

  assign digit     = operand[idx*DIGIT_W +: DIGIT_W];
  assign err_final = err_acc | (digit > BCD_MAX);

  mul10_add #(.W(ACC_W)) u_mul10_add (
    .acc   (acc),
    .digit (digit),
    .sum   (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.valid = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_CONV;
      S_CONV: begin
        bus.busy = 1'b1;
        if (idx == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.busy  = 1'b1;
        bus.valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      operand <= '0;
      acc     <= '0;
      idx     <= '0;
      err_acc <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (bus.start) begin
          operand <= bus.bcd_in;
          acc     <= '0;
          idx     <= IDX_W'(N_DIGITS - 1);
          err_acc <= 1'b0;
        end
        S_CONV: begin
          acc     <= acc_nxt;
          err_acc <= err_final;
          // Results land on the last digit so they are already stable during valid.
          if (idx == '0) begin
            bin_q <= err_final ? '0 : acc_nxt[BIN_W-1:0];
            err_q <= err_final;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed-vector bench for bcd2bin_seq with hand-computed expected results.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  bcd2bin_seq_if #(.N_DIGITS(6), .BIN_W(20)) bus ();

  bcd2bin_seq #(.N_DIGITS(6), .BIN_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus only: one start pulse then ten observed cycles.
  task automatic run_conv(input logic [23:0] v, output int busy_n, output int vcnt,
                          output int vk, output logic [19:0] got, output logic gerr);
    busy_n = 0; vcnt = 0; vk = -1; got = '0; gerr = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.bcd_in = v;
    @(negedge clk); bus.start = 1'b0; bus.bcd_in = 24'hFFFFFF;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.valid) begin vcnt++; vk = k; got = bus.bin_out; gerr = bus.err; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b1; bus.bcd_in = 24'h123456;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.bcd_in = $urandom_range(0, 24'hFFFFFF);
      total_cnt++;
      if ({bus.busy, bus.valid, bus.err, bus.bin_out} !== 23'd0)
        $display("FAIL reset_outputs cycle %0d: busy=%b valid=%b err=%b bin_out=%0d, required all 0",
                 i, bus.busy, bus.valid, bus.err, bus.bin_out);
      else pass_cnt++;
    end
    bus.start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0)
        $display("FAIL reset_idle cycle %0d: busy=%b valid=%b, required 0 0", i, bus.busy, bus.valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_conv(input string nm, input logic [23:0] v,
                           input logic [19:0] exp_bin, input logic exp_err);
    int busy_n, vcnt, vk; logic [19:0] got; logic gerr;
    run_conv(v, busy_n, vcnt, vk, got, gerr);
    total_cnt++;
    if (busy_n !== 7) $display("FAIL %s busy_cycles: got %0d required 7", nm, busy_n);
    else pass_cnt++;
    total_cnt++;
    if (vcnt !== 1 || vk !== 6)
      $display("FAIL %s valid_timing: count %0d at cycle %0d, required 1 at 6", nm, vcnt, vk);
    else pass_cnt++;
    total_cnt++;
    if (got !== exp_bin || gerr !== exp_err)
      $display("FAIL %s result: bin_out=%0d err=%b, required %0d %b", nm, got, gerr, exp_bin, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (bus.bin_out !== exp_bin || bus.err !== exp_err)
      $display("FAIL %s hold: bin_out=%0d err=%b, required %0d %b", nm, bus.bin_out, bus.err, exp_bin, exp_err);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    test_conv("basic_999999", 24'h999999, 20'd999999, 1'b0);
  endtask

  task automatic test_mixed();
    test_conv("zero", 24'h000000, 20'd0, 1'b0);
    test_conv("mix_012345", 24'h012345, 20'd12345, 1'b0);
    test_conv("mix_100000", 24'h100000, 20'd100000, 1'b0);
  endtask

  task automatic test_invalid();
    test_conv("invalid_12A456", 24'h12A456, 20'd0, 1'b1);
    test_conv("after_err_42", 24'h000042, 20'd42, 1'b0);
  endtask

  task automatic test_handshake();
    int vcnt = 0; logic [19:0] got = '0;
    @(negedge clk); bus.start = 1'b1; bus.bcd_in = 24'h000111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.start  = (k == 2);
      bus.bcd_in = (k == 2) ? 24'h000222 : 24'h000000;
      if (bus.valid) begin vcnt++; got = bus.bin_out; end
    end
    total_cnt++;
    if (vcnt !== 1) $display("FAIL handshake_valid_count: got %0d required 1", vcnt);
    else pass_cnt++;
    total_cnt++;
    if (got !== 20'd111 || bus.bin_out !== 20'd111)
      $display("FAIL handshake_result: at valid %0d now %0d, required 111", got, bus.bin_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int vk[$]; int bad_val = 0;
    @(negedge clk); bus.start = 1'b1; bus.bcd_in = 24'h000333;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.valid) begin
        vk.push_back(k);
        if (bus.bin_out !== 20'd333 || bus.err !== 1'b0) bad_val++;
      end
    end
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (vk.size() !== 3) $display("FAIL b2b_valid_count: got %0d required 3", vk.size());
    else pass_cnt++;
    total_cnt++;
    if (vk.size() < 3 || vk[0] !== 6 || vk[1] - vk[0] !== 8 || vk[2] - vk[1] !== 8)
      $display("FAIL b2b_spacing: first %0d count %0d, required first 6 spacing 8",
               (vk.size() > 0) ? vk[0] : -1, vk.size());
    else pass_cnt++;
    total_cnt++;
    if (bad_val !== 0) $display("FAIL b2b_values: %0d bad results, required 0 (value 333)", bad_val);
    else pass_cnt++;
  endtask

  task automatic test_midop_reset();
    int vcnt = 0;
    @(negedge clk); bus.start = 1'b1; bus.bcd_in = 24'h555555;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.valid, bus.err, bus.bin_out} !== 23'd0)
      $display("FAIL midop_reset_outputs: busy=%b valid=%b err=%b bin_out=%0d, required all 0",
               bus.busy, bus.valid, bus.err, bus.bin_out);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.valid) vcnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) vcnt++;
    end
    total_cnt++;
    if (vcnt !== 0) $display("FAIL midop_no_valid: %0d active cycles, required 0", vcnt);
    else pass_cnt++;
    test_conv("after_reset_7", 24'h000007, 20'd7, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.bcd_in = '0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_mixed();
    test_invalid();
    test_handshake();
    test_back_to_back();
    test_midop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
